// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the two-requester UART transmit arbiter.
package uart_tx_arbiter_pkg;

    localparam int unsigned DATA_W              = 8;
    localparam int unsigned NUM_REQ             = 2;
    localparam int unsigned DEFAULT_TIMEOUT_CYC = 100000;
    localparam int unsigned DEFAULT_TW          = 17;

    typedef logic [DATA_W-1:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

endpackage

// File: rtl/tx_hold_slot.sv
// One requester's holding register: a byte, its pending bit and a sticky overrun flag.
module tx_hold_slot
    import uart_tx_arbiter_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  send,
    input  byte_t send_data,
    input  logic  clear,
    output byte_t data,
    output logic  pending,
    output logic  overrun
);

    // A send landing on the clearing edge still sees pending=1, so it is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data    <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (send && pending) begin
                overrun <= 1'b1;
            end
            if (clear) begin
                pending <= 1'b0;
            end else if (send && !pending) begin
                pending <= 1'b1;
                data    <= send_data;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from two holding slots into a single UART writer.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter int unsigned TW          = DEFAULT_TW
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [1:0]        r_send,
    input  logic [DATA_W-1:0] r_data0,
    input  logic [DATA_W-1:0] r_data1,
    output logic [1:0]        r_ready,
    output logic [1:0]        r_finish,
    output logic [1:0]        r_overrun,
    input  logic              u_ready,
    output logic              u_send,
    output logic [DATA_W-1:0] u_data,
    input  logic              u_finish,
    output logic              timeout_err
);

    logic [1:0]    pending;
    logic [1:0]    slot_clear;
    byte_t         slot_data0;
    byte_t         slot_data1;

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_q, last_d;
    logic [TW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          u_send_d;
    byte_t         u_data_d;
    logic [1:0]    r_finish_d;
    logic          timeout_err_d;

    tx_hold_slot u_slot0 (
        .clk       (Clock),
        .rst_n     (Reset),
        .send      (r_send[0]),
        .send_data (r_data0),
        .clear     (slot_clear[0]),
        .data      (slot_data0),
        .pending   (pending[0]),
        .overrun   (r_overrun[0])
    );

    tx_hold_slot u_slot1 (
        .clk       (Clock),
        .rst_n     (Reset),
        .send      (r_send[1]),
        .send_data (r_data1),
        .clear     (slot_clear[1]),
        .data      (slot_data1),
        .pending   (pending[1]),
        .overrun   (r_overrun[1])
    );

    assign r_ready = ~pending;
    assign cnt_inc = cnt_q + TW'(1);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            u_send      <= 1'b0;
            u_data      <= '0;
            r_finish    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            u_send      <= u_send_d;
            u_data      <= u_data_d;
            r_finish    <= r_finish_d;
            timeout_err <= timeout_err_d;
        end
    end

    // Next-state and registered-output logic; a transfer ends on finish or timeout.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        u_send_d      = 1'b0;
        u_data_d      = u_data;
        r_finish_d    = '0;
        timeout_err_d = timeout_err;
        slot_clear    = '0;

        case (state_q)
            ST_IDLE: begin
                if (u_ready && (pending != 2'b00)) begin
                    if (pending == 2'b11) begin
                        grant_d = ~last_q;
                    end else begin
                        grant_d = pending[1];
                    end
                    u_data_d = grant_d ? slot_data1 : slot_data0;
                    u_send_d = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (u_finish) begin
                    r_finish_d[grant_q] = 1'b1;
                    slot_clear[grant_q] = 1'b1;
                    last_d              = grant_q;
                    state_d             = ST_IDLE;
                end else if (cnt_inc == TW'(TIMEOUT_CYC)) begin
                    timeout_err_d       = 1'b1;
                    slot_clear[grant_q] = 1'b1;
                    last_d              = grant_q;
                    cnt_d               = cnt_inc;
                    state_d             = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table for single/contention transfers plus corner sequences.
module tb_uart_tx_arbiter;

    logic       Clock;
    logic       Reset;
    logic [1:0] r_send;
    logic [7:0] r_data0;
    logic [7:0] r_data1;
    logic [1:0] r_ready;
    logic [1:0] r_finish;
    logic [1:0] r_overrun;
    logic       u_ready;
    logic       u_send;
    logic [7:0] u_data;
    logic       u_finish;
    logic       timeout_err;

    int checks;
    int failures;

    typedef struct {
        logic [1:0] send;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] exp_ready;
        logic [7:0] exp_data0;
        logic [1:0] exp_fin0;
        logic [7:0] exp_data1;
        logic [1:0] exp_fin1;
    } vec_t;

    vec_t vecs [5];

    uart_tx_arbiter #(
        .TIMEOUT_CYC (8),
        .TW          (4)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .r_send      (r_send),
        .r_data0     (r_data0),
        .r_data1     (r_data1),
        .r_ready     (r_ready),
        .r_finish    (r_finish),
        .r_overrun   (r_overrun),
        .u_ready     (u_ready),
        .u_send      (u_send),
        .u_data      (u_data),
        .u_finish    (u_finish),
        .timeout_err (timeout_err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_usend(input int bound, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i <= bound; i++) begin
            if (u_send === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (i < bound) step();
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: u_send not seen within %0d cycles", name, bound);
        end
    endtask

    // Two BUSY cycles, one u_finish pulse, then check the r_finish pulse and its width.
    task automatic finish_txn(input string name, input logic [1:0] exp_fin);
        step();
        step();
        u_finish = 1'b1;
        step();
        u_finish = 1'b0;
        chk({name, " r_finish"}, 32'(r_finish), 32'(exp_fin));
        step();
        chk({name, " r_finish width"}, 32'(r_finish), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        Reset    = 1'b0;
        r_send   = 2'b00;
        r_data0  = 8'h00;
        r_data1  = 8'h00;
        u_ready  = 1'b1;
        u_finish = 1'b0;

        vecs[0] = '{2'b11, 8'hAA, 8'h55, 2'b00, 8'hAA, 2'b01, 8'h55, 2'b10};
        vecs[1] = '{2'b01, 8'h41, 8'h00, 2'b10, 8'h41, 2'b01, 8'h00, 2'b00};
        vecs[2] = '{2'b11, 8'hC3, 8'h3C, 2'b00, 8'h3C, 2'b10, 8'hC3, 2'b01};
        vecs[3] = '{2'b10, 8'h00, 8'h7E, 2'b01, 8'h7E, 2'b10, 8'h00, 2'b00};
        vecs[4] = '{2'b11, 8'h5A, 8'hA5, 2'b00, 8'h5A, 2'b01, 8'hA5, 2'b10};

        repeat (3) step();
        chk("reset r_ready",     32'(r_ready),     32'h3);
        chk("reset r_finish",    32'(r_finish),    32'h0);
        chk("reset r_overrun",   32'(r_overrun),   32'h0);
        chk("reset u_send",      32'(u_send),      32'h0);
        chk("reset u_data",      32'(u_data),      32'h0);
        chk("reset timeout_err", 32'(timeout_err), 32'h0);
        Reset = 1'b1;
        step();

        for (int v = 0; v < 5; v++) begin
            r_send  = vecs[v].send;
            r_data0 = vecs[v].d0;
            r_data1 = vecs[v].d1;
            step();
            r_send = 2'b00;
            chk($sformatf("vec%0d r_ready after send", v), 32'(r_ready), 32'(vecs[v].exp_ready));
            chk($sformatf("vec%0d u_send at N+1", v), 32'(u_send), 32'h0);
            step();
            chk($sformatf("vec%0d u_send at N+2", v), 32'(u_send), 32'h1);
            chk($sformatf("vec%0d u_data first", v), 32'(u_data), 32'(vecs[v].exp_data0));
            finish_txn($sformatf("vec%0d first", v), vecs[v].exp_fin0);
            if (vecs[v].send == 2'b11) begin
                wait_usend(4, $sformatf("vec%0d second u_send", v));
                chk($sformatf("vec%0d u_data second", v), 32'(u_data), 32'(vecs[v].exp_data1));
                finish_txn($sformatf("vec%0d second", v), vecs[v].exp_fin1);
            end
            chk($sformatf("vec%0d r_ready idle", v), 32'(r_ready), 32'h3);
            chk($sformatf("vec%0d r_overrun", v), 32'(r_overrun), 32'h0);
            chk($sformatf("vec%0d timeout_err", v), 32'(timeout_err), 32'h0);
        end

        // Overrun: second send to requester 1 while its byte is still pending.
        r_send  = 2'b10;
        r_data1 = 8'h11;
        step();
        r_data1 = 8'h22;
        step();
        r_send = 2'b00;
        chk("ovr r_overrun", 32'(r_overrun), 32'h2);
        chk("ovr u_send",    32'(u_send),    32'h1);
        chk("ovr u_data",    32'(u_data),    32'h11);
        finish_txn("ovr", 2'b10);
        chk("ovr r_ready", 32'(r_ready), 32'h3);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ovr dropped byte not sent", 32'(u_send), 32'h0);
        end

        // Send on the same edge pending clears is dropped and flags overrun.
        r_send  = 2'b01;
        r_data0 = 8'h33;
        step();
        r_send = 2'b00;
        wait_usend(3, "coinc u_send");
        chk("coinc u_data", 32'(u_data), 32'h33);
        step();
        step();
        u_finish = 1'b1;
        r_send   = 2'b01;
        r_data0  = 8'h44;
        step();
        u_finish = 1'b0;
        r_send   = 2'b00;
        chk("coinc r_finish",  32'(r_finish),  32'h1);
        chk("coinc r_overrun", 32'(r_overrun), 32'h3);
        chk("coinc r_ready",   32'(r_ready),   32'h3);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("coinc dropped byte not sent", 32'(u_send), 32'h0);
        end

        // UART writer busy: nothing issued until u_ready rises.
        u_ready = 1'b0;
        r_send  = 2'b01;
        r_data0 = 8'h66;
        step();
        r_send = 2'b00;
        for (int i = 0; i < 5; i++) begin
            chk("busy u_send held", 32'(u_send), 32'h0);
            chk("busy r_ready",     32'(r_ready), 32'h2);
            step();
        end
        u_ready = 1'b1;
        wait_usend(2, "busy u_send after u_ready");
        chk("busy u_data", 32'(u_data), 32'h66);
        finish_txn("busy", 2'b01);

        // Timeout: u_finish withheld for 8 BUSY cycles.
        r_send  = 2'b10;
        r_data1 = 8'h77;
        step();
        r_send = 2'b00;
        wait_usend(3, "to u_send");
        chk("to u_data", 32'(u_data), 32'h77);
        for (int b = 1; b <= 8; b++) begin
            step();
            chk($sformatf("to busy%0d r_finish", b), 32'(r_finish), 32'h0);
            chk($sformatf("to busy%0d timeout_err", b), 32'(timeout_err), 32'h0);
        end
        step();
        chk("to timeout_err set", 32'(timeout_err), 32'h1);
        chk("to r_ready",         32'(r_ready),     32'h3);
        chk("to r_finish",        32'(r_finish),    32'h0);
        u_finish = 1'b1;
        step();
        u_finish = 1'b0;
        chk("stray u_finish ignored", 32'(r_finish), 32'h0);
        chk("stray u_send",           32'(u_send),   32'h0);
        r_send  = 2'b01;
        r_data0 = 8'h88;
        step();
        r_send = 2'b00;
        wait_usend(3, "post-to u_send");
        chk("post-to u_data", 32'(u_data), 32'h88);
        finish_txn("post-to", 2'b01);
        chk("timeout_err sticky", 32'(timeout_err), 32'h1);

        // Reset while BUSY aborts without a finish pulse.
        r_send  = 2'b01;
        r_data0 = 8'h99;
        step();
        r_send = 2'b00;
        wait_usend(3, "rst u_send");
        step();
        step();
        #2;
        Reset = 1'b0;
        #1;
        chk("rst r_ready",     32'(r_ready),     32'h3);
        chk("rst r_finish",    32'(r_finish),    32'h0);
        chk("rst r_overrun",   32'(r_overrun),   32'h0);
        chk("rst u_send",      32'(u_send),      32'h0);
        chk("rst u_data",      32'(u_data),      32'h0);
        chk("rst timeout_err", 32'(timeout_err), 32'h0);
        step();
        Reset    = 1'b1;
        u_finish = 1'b1;
        step();
        u_finish = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post-rst r_finish", 32'(r_finish), 32'h0);
            chk("post-rst u_send",   32'(u_send),   32'h0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
